// File: rtl/mpsoc_ahb3_spram_bridge.sv
// AHB3-Lite slave that maps 16-bit transfers onto a single-port synchronous RAM.
// Reads issue in their address phase. A read that follows a write directly waits one cycle.
module mpsoc_ahb3_spram_bridge #(
    parameter int AW       = 6,
    parameter int DW       = 16,
    parameter int MEM_SIZE = 256
) (
    input  logic          mclk,
    input  logic          puc_rst,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [DW-1:0] HWDATA,
    output logic [DW-1:0] HRDATA,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [2:0]    HBURST,
    input  logic [3:0]    HPROT,
    input  logic [1:0]    HTRANS,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_cen,
    output logic [1:0]    ram_wen
);

    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, ERR1, ERR2} state_t;

    state_t        state, state_next;
    logic          ready;
    logic          accept;
    logic          addr_err;
    logic [1:0]    wen_next;
    logic [AW-1:0] addr_r;
    logic [1:0]    wen_r;
    logic          unused_ok;

    assign unused_ok = ^{HBURST, HPROT};

    assign ready     = !(state == ERR1 || state == RD_WAIT);
    assign HREADYOUT = ready;
    assign HRESP     = (state == ERR1) || (state == ERR2);
    assign HRDATA    = (state == RD) ? ram_dout : '0;

    // Gating with puc_rst keeps the combinational read path quiet while in reset.
    assign accept   = HSEL && HREADY && HTRANS[1] && ready && !puc_rst;
    assign addr_err = (HSIZE > 3'd1) || (HADDR >= 32'(MEM_SIZE)) ||
                      ((HSIZE == 3'd1) && HADDR[0]);
    assign wen_next = HSIZE[0] ? 2'b00 : (HADDR[0] ? 2'b01 : 2'b10);

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state  <= IDLE;
            addr_r <= '0;
            wen_r  <= '1;
        end else begin
            state <= state_next;
            if (accept && !addr_err) begin
                addr_r <= HADDR[AW:1];
                wen_r  <= wen_next;
            end
        end
    end

    always_comb begin
        state_next = IDLE;
        if (state == ERR1) begin
            state_next = ERR2;
        end else if (state == RD_WAIT) begin
            state_next = RD;
        end else if (accept) begin
            if (addr_err)
                state_next = ERR1;
            else if (HWRITE)
                state_next = WR;
            else if (state == WR)
                state_next = RD_WAIT;
            else
                state_next = RD;
        end
    end

    always_comb begin
        ram_cen  = 1'b1;
        ram_wen  = '1;
        ram_addr = '0;
        ram_din  = '0;
        case (state)
            WR: begin
                ram_cen  = 1'b0;
                ram_wen  = wen_r;
                ram_addr = addr_r;
                ram_din  = HWDATA;
            end
            RD_WAIT: begin
                ram_cen  = 1'b0;
                ram_addr = addr_r;
            end
            default: begin
                if (accept && !addr_err && !HWRITE) begin
                    ram_cen  = 1'b0;
                    ram_addr = HADDR[AW:1];
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mpsoc_ahb3_spram_bridge.sv
// Bench for mpsoc_ahb3_spram_bridge: directed cases, then random AHB traffic
// compared against a byte-array memory model.
module tb_mpsoc_ahb3_spram_bridge;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [15:0] hwdata;
    logic [15:0] hrdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hreadyout;
    logic        hresp;
    logic [5:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic        ram_cen;
    logic [1:0]  ram_wen;

    always #5 mclk = ~mclk;

    mpsoc_ahb3_spram_bridge #(.AW(6), .DW(16), .MEM_SIZE(256)) dut (
        .mclk(mclk), .puc_rst(puc_rst),
        .HSEL(hsel), .HADDR(haddr), .HWDATA(hwdata), .HRDATA(hrdata),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HREADY(hreadyout), .HREADYOUT(hreadyout), .HRESP(hresp),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_cen(ram_cen), .ram_wen(ram_wen)
    );

    // Synchronous single-port RAM attached to the bridge
    logic [15:0] ram [64];
    initial for (int i = 0; i < 64; i++) ram[i] = 16'h0000;
    always @(posedge mclk) begin
        if (!ram_cen) begin
            if (!ram_wen[0]) ram[ram_addr][7:0]  <= ram_din[7:0];
            if (!ram_wen[1]) ram[ram_addr][15:8] <= ram_din[15:8];
            ram_dout <= ram[ram_addr];
        end
    end

    // Reference: byte-addressed memory and the pending data phase
    logic [7:0]  ref_mem [128];
    int          checks   = 0;
    int          failures = 0;
    logic        p_valid, p_err, p_write, p_raw;
    logic [31:0] p_addr;
    logic [2:0]  p_size;
    logic [15:0] p_wdata, p_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_err(input logic [31:0] a, input logic [2:0] s);
        return (s > 3'd1) || (a >= 32'd256) || (s == 3'd1 && a[0]);
    endfunction

    function automatic logic [15:0] model_read(input logic [31:0] a);
        int unsigned b;
        b = a & 32'h7E;
        return {ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [15:0] d);
        int unsigned b;
        b = a & 32'h7F;
        if (s == 3'd1) begin
            ref_mem[b]   = d[7:0];
            ref_mem[b+1] = d[15:8];
        end else begin
            ref_mem[b] = a[0] ? d[15:8] : d[7:0];
        end
    endtask

    // One address phase; runs the pending data phase to completion and checks it.
    task automatic beat(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [31:0] addr, input logic [2:0] size, input logic [15:0] wd);
        int unsigned ncyc;
        logic        vnew, enew, last;
        logic [1:0]  wexp;
        hsel   = sel;
        htrans = trans;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        hburst = 3'($urandom);
        hprot  = 4'($urandom);
        hwdata = (p_valid && p_write) ? p_wdata : 16'($urandom);
        vnew = sel && trans[1];
        enew = vnew && is_err(addr, size);
        ncyc = (p_valid && (p_err || p_raw)) ? 2 : 1;
        for (int c = 0; c < int'(ncyc); c++) begin
            @(negedge mclk);
            last = (c == int'(ncyc) - 1);
            chk("hreadyout", {31'd0, hreadyout}, {31'd0, last});
            chk("hresp", {31'd0, hresp}, {31'd0, p_valid && p_err});
            if (p_valid && p_write) begin
                wexp = (p_size == 3'd1) ? 2'b00 : (p_addr[0] ? 2'b01 : 2'b10);
                chk("wr_cen", {31'd0, ram_cen}, 32'd0);
                chk("wr_wen", {30'd0, ram_wen}, {30'd0, wexp});
                chk("wr_addr", {26'd0, ram_addr}, {26'd0, p_addr[6:1]});
                chk("wr_din", {16'd0, ram_din}, {16'd0, p_wdata});
            end else if (p_valid && p_raw && !last) begin
                chk("rdw_cen", {31'd0, ram_cen}, 32'd0);
                chk("rdw_wen", {30'd0, ram_wen}, 32'd3);
                chk("rdw_addr", {26'd0, ram_addr}, {26'd0, p_addr[6:1]});
            end else if (last && vnew && !enew && !wr) begin
                chk("rd_cen", {31'd0, ram_cen}, 32'd0);
                chk("rd_wen", {30'd0, ram_wen}, 32'd3);
                chk("rd_addr", {26'd0, ram_addr}, {26'd0, addr[6:1]});
            end else begin
                chk("idle_cen", {31'd0, ram_cen}, 32'd1);
                chk("idle_wen", {30'd0, ram_wen}, 32'd3);
            end
            if (last && p_valid && !p_write && !p_err)
                chk("hrdata", {16'd0, hrdata}, {16'd0, p_exp});
            @(posedge mclk);
            #1;
        end
        p_raw   = vnew && !enew && !wr && p_valid && p_write;
        p_valid = vnew;
        p_err   = enew;
        p_write = vnew && !enew && wr;
        p_addr  = addr;
        p_size  = size;
        p_wdata = wd;
        if (p_write) model_write(addr, size, wd);
        if (vnew && !enew && !wr) p_exp = model_read(addr);
    endtask

    task automatic idle();
        beat(1'b0, 2'b00, 1'b0, 32'h0, 3'd1, 16'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [15:0] d);
        beat(1'b1, 2'b10, 1'b1, a, s, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] s);
        beat(1'b1, 2'b10, 1'b0, a, s, 16'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  s;
        int unsigned r;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
        p_valid = 1'b0; p_err = 1'b0; p_write = 1'b0; p_raw = 1'b0;
        p_addr = '0; p_size = '0; p_wdata = '0; p_exp = '0;
        hburst = '0; hprot = '0; hwdata = '0;

        // Reset with a live read address phase on the bus
        puc_rst = 1'b1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h4; hsize = 3'd1;
        for (int i = 0; i < 2; i++) begin
            @(negedge mclk);
            chk("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
            chk("rst_hresp", {31'd0, hresp}, 32'd0);
            chk("rst_cen", {31'd0, ram_cen}, 32'd1);
            chk("rst_wen", {30'd0, ram_wen}, 32'd3);
            chk("rst_addr", {26'd0, ram_addr}, 32'd0);
            chk("rst_din", {16'd0, ram_din}, 32'd0);
            chk("rst_hrdata", {16'd0, hrdata}, 32'd0);
        end
        hsel = 1'b0; htrans = 2'b00;
        @(posedge mclk);
        #1 puc_rst = 1'b0;

        // Halfword write, idle, read with zero wait states
        wr(32'h4, 3'd1, 16'hBEEF);
        idle();
        rd(32'h4, 3'd1);
        idle();

        // Back-to-back write then read of the same address
        wr(32'h10, 3'd1, 16'h1234);
        rd(32'h10, 3'd1);
        idle();

        // Byte writes on both lanes, then halfword read
        wr(32'h21, 3'd0, 16'hAA00);
        wr(32'h20, 3'd0, 16'h0055);
        idle();
        rd(32'h20, 3'd1);
        idle();
        chk("byte_merge", {16'd0, p_exp}, 32'h0000AA55);

        // Error responses: out of range, misaligned halfword, oversize
        rd(32'h100, 3'd1);
        idle();
        rd(32'h3, 3'd1);
        idle();
        wr(32'h8, 3'd2, 16'h7777);
        idle();

        // BUSY is answered like IDLE
        beat(1'b1, 2'b01, 1'b1, 32'h6, 3'd1, 16'h0);
        idle();

        // Reset pulsed inside a write data phase aborts the write
        wr(32'h30, 3'd1, 16'h1357);
        idle();
        wr(32'h30, 3'd1, 16'h2468);
        hsel = 1'b0; htrans = 2'b00; hwdata = 16'h2468;
        puc_rst = 1'b1;
        #1;
        chk("abort_cen", {31'd0, ram_cen}, 32'd1);
        chk("abort_wen", {30'd0, ram_wen}, 32'd3);
        chk("abort_addr", {26'd0, ram_addr}, 32'd0);
        chk("abort_din", {16'd0, ram_din}, 32'd0);
        chk("abort_hreadyout", {31'd0, hreadyout}, 32'd1);
        chk("abort_hresp", {31'd0, hresp}, 32'd0);
        chk("abort_hrdata", {16'd0, hrdata}, 32'd0);
        @(posedge mclk);
        #1 puc_rst = 1'b0;
        ref_mem[8'h30] = 8'h57;
        ref_mem[8'h31] = 8'h13;
        p_valid = 1'b0; p_write = 1'b0; p_err = 1'b0; p_raw = 1'b0;
        rd(32'h30, 3'd1);
        idle();
        chk("abort_old_data", {16'd0, p_exp}, 32'h00001357);

        // Random pipelined traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                beat(1'($urandom), 2'($urandom_range(0, 1)), 1'($urandom), 32'($urandom), 3'd1, 16'h0);
            end else begin
                s = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'($urandom_range(0, 1));
                if ($urandom_range(0, 19) == 0)
                    a = 32'h100 + 32'($urandom_range(0, 1023));
                else
                    a = 32'($urandom_range(0, 127));
                if (s == 3'd1 && $urandom_range(0, 5) != 0) a[0] = 1'b0;
                if ($urandom_range(0, 1) == 1)
                    wr(a, s, 16'($urandom));
                else
                    rd(a, s);
            end
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
